lif_scheduler: RTL and testbench



---
 rtl/lif_scheduler.sv | 157 +++++++++++++++
 tb/tb_lif_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky-integrate-and-fire controller: one shared membrane
// update datapath swept over N_NEURONS virtual neurons per tick.
module lif_scheduler #(
  parameter int          N_NEURONS  = 4,
  parameter logic [7:0]  THRESHOLD  = 8'd200,
  parameter int          LEAK_SHIFT = 2,
  localparam int         IW         = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // Stimulus port: a write transfers on any rising edge where in_valid and
  // in_ready are both high; in_ready never depends on in_valid.
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IW-1:0]        in_idx,
  input  logic [7:0]           in_current,
  input  logic [7:0]           in_weight,
  input  logic                 tick,
  output logic                 busy,
  output logic                 done,
  output logic                 spike_valid,
  output logic [IW-1:0]        spike_idx,
  output logic [N_NEURONS-1:0] spikes,
  input  logic [IW-1:0]        rd_idx,
  output logic [7:0]           rd_state,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UPDATE, S_DONE} fsm_e;

  fsm_e                 fsm_q, fsm_d;
  logic [IW-1:0]        n_q, n_d;
  logic [7:0]           state_q    [N_NEURONS];
  logic [7:0]           state_d    [N_NEURONS];
  logic [7:0]           pend_cur_q [N_NEURONS];
  logic [7:0]           pend_cur_d [N_NEURONS];
  logic [7:0]           pend_wt_q  [N_NEURONS];
  logic [7:0]           pend_wt_d  [N_NEURONS];
  logic [7:0]           op_state_q, op_state_d;
  logic [7:0]           op_cur_q, op_cur_d;
  logic [7:0]           op_wt_q, op_wt_d;
  logic [N_NEURONS-1:0] scratch_q, scratch_d;
  logic [N_NEURONS-1:0] spikes_q, spikes_d;
  logic                 spike_valid_q, spike_valid_d;
  logic [IW-1:0]        spike_idx_q, spike_idx_d;
  logic [7:0]           rd_state_q, rd_state_d;

  logic [15:0] prod;
  logic [7:0]  term;
  logic [7:0]  leak;
  logic [8:0]  sum9;
  logic [7:0]  sum_sat;
  logic        fire;

  // Leak never exceeds state, so the 9-bit sum cannot underflow; only overflow saturates.
  assign prod    = {8'd0, op_cur_q} * {8'd0, op_wt_q};
  assign term    = prod[15:8];
  assign leak    = op_state_q >> LEAK_SHIFT;
  assign sum9    = {1'b0, op_state_q} - {1'b0, leak} + {1'b0, term};
  assign sum_sat = sum9[8] ? 8'hFF : sum9[7:0];
  assign fire    = (sum_sat >= THRESHOLD);

  always_comb begin
    fsm_d         = fsm_q;
    n_d           = n_q;
    state_d       = state_q;
    pend_cur_d    = pend_cur_q;
    pend_wt_d     = pend_wt_q;
    op_state_d    = op_state_q;
    op_cur_d      = op_cur_q;
    op_wt_d       = op_wt_q;
    scratch_d     = scratch_q;
    spikes_d      = spikes_q;
    spike_valid_d = 1'b0;
    spike_idx_d   = spike_idx_q;
    rd_state_d    = state_q[rd_idx];
    case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          pend_cur_d[in_idx] = in_current;
          pend_wt_d[in_idx]  = in_weight;
        end
        if (tick) begin
          fsm_d     = S_LOAD;
          n_d       = '0;
          scratch_d = '0;
        end
      end
      S_LOAD: begin
        op_state_d = state_q[n_q];
        op_cur_d   = pend_cur_q[n_q];
        op_wt_d    = pend_wt_q[n_q];
        fsm_d      = S_UPDATE;
      end
      S_UPDATE: begin
        state_d[n_q]    = fire ? 8'd0 : sum_sat;
        pend_cur_d[n_q] = 8'd0;
        if (fire) begin
          scratch_d[n_q] = 1'b1;
          spike_valid_d  = 1'b1;
          spike_idx_d    = n_q;
        end
        if (n_q == IW'(N_NEURONS - 1)) begin
          fsm_d    = S_DONE;
          spikes_d = scratch_d;
        end else begin
          fsm_d = S_LOAD;
          n_d   = n_q + IW'(1);
        end
      end
      S_DONE:  fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q         <= S_IDLE;
      n_q           <= '0;
      state_q       <= '{default: '0};
      pend_cur_q    <= '{default: '0};
      pend_wt_q     <= '{default: '0};
      op_state_q    <= '0;
      op_cur_q      <= '0;
      op_wt_q       <= '0;
      scratch_q     <= '0;
      spikes_q      <= '0;
      spike_valid_q <= 1'b0;
      spike_idx_q   <= '0;
      rd_state_q    <= '0;
    end else begin
      fsm_q         <= fsm_d;
      n_q           <= n_d;
      state_q       <= state_d;
      pend_cur_q    <= pend_cur_d;
      pend_wt_q     <= pend_wt_d;
      op_state_q    <= op_state_d;
      op_cur_q      <= op_cur_d;
      op_wt_q       <= op_wt_d;
      scratch_q     <= scratch_d;
      spikes_q      <= spikes_d;
      spike_valid_q <= spike_valid_d;
      spike_idx_q   <= spike_idx_d;
      rd_state_q    <= rd_state_d;
    end
  end

  assign in_ready    = (fsm_q == S_IDLE);
  assign busy        = (fsm_q != S_IDLE);
  assign done        = (fsm_q == S_DONE);
  assign spike_valid = spike_valid_q;
  assign spike_idx   = spike_idx_q;
  assign spikes      = spikes_q;
  assign rd_state    = rd_state_q;
  assign dbg_state   = fsm_q;

endmodule

// File: tb/tb_lif_scheduler.sv
// Directed bench for lif_scheduler: reset, fire, integration/leak, handshake
// stall, simultaneous tick+write and reset in the middle of a sweep.
module tb_lif_scheduler;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_idx;
  logic [7:0]    in_current;
  logic [7:0]    in_weight;
  logic          tick;
  logic          busy;
  logic          done;
  logic          spike_valid;
  logic [IW-1:0] spike_idx;
  logic [N-1:0]  spikes;
  logic [IW-1:0] rd_idx;
  logic [7:0]    rd_state;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations collected by run_sweep
  logic [N-1:0] seen;
  logic         done_at_end;
  int           busy_cnt;
  int           done_cnt;

  lif_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
    .in_current(in_current), .in_weight(in_weight),
    .tick(tick), .busy(busy), .done(done),
    .spike_valid(spike_valid), .spike_idx(spike_idx), .spikes(spikes),
    .rd_idx(rd_idx), .rd_state(rd_state), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; sample and drive 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic write_stim(input int idx, input int cur, input int wt);
    in_valid   = 1'b1;
    in_idx     = IW'(idx);
    in_current = 8'(cur);
    in_weight  = 8'(wt);
    step();
    in_valid   = 1'b0;
  endtask

  task automatic read_state(input int idx, output logic [7:0] val);
    rd_idx = IW'(idx);
    step();
    val = rd_state;
  endtask

  // Tick from IDLE and run to the IDLE cycle T+2N+2, logging spikes/busy/done.
  task automatic run_sweep();
    seen     = '0;
    busy_cnt = 0;
    done_cnt = 0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int k = 1; k <= 2 * N + 1; k++) begin
      if (spike_valid) seen[spike_idx] = 1'b1;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (k == 2 * N + 1) done_at_end = done;
      step();
    end
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] exp_int [5];
    exp_int = '{8'd64, 8'd112, 8'd148, 8'd175, 8'd196};
    rst_n = 1'b0; in_valid = 1'b0; in_idx = '0; in_current = '0;
    in_weight = '0; tick = 1'b0; rd_idx = '0;

    // Reset values
    apply_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_spike_valid", spike_valid, 0);
    check("rst_spike_idx", spike_idx, 0);
    check("rst_spikes", spikes, 0);
    for (int i = 0; i < N; i++) begin
      read_state(i, v);
      check($sformatf("rst_rd_state%0d", i), v, 0);
    end

    // Single fire on n0
    apply_reset();
    write_stim(0, 255, 255);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("fire_busy_t1", busy, 1);
    check("fire_ready_t1", in_ready, 0);
    step();
    check("fire_sv_t2", spike_valid, 0);
    step();
    check("fire_sv_t3", spike_valid, 1);
    check("fire_idx_t3", spike_idx, 0);
    step();
    check("fire_sv_t4", spike_valid, 0);
    repeat (5) step();
    check("fire_done_t9", done, 1);
    check("fire_spikes_t9", spikes, 4'b0001);
    check("fire_busy_t9", busy, 1);
    step();
    check("fire_done_t10", done, 0);
    check("fire_busy_t10", busy, 0);
    check("fire_ready_t10", in_ready, 1);
    check("fire_spikes_hold", spikes, 4'b0001);
    read_state(0, v);
    check("fire_state0", v, 0);

    // Integration and leak on n1, rewritten before each tick
    apply_reset();
    for (int t = 0; t < 5; t++) begin
      write_stim(1, 128, 128);
      run_sweep();
      check($sformatf("int_nospike%0d", t + 1), seen, 0);
      read_state(1, v);
      check($sformatf("int_state%0d", t + 1), v, exp_int[t]);
    end
    write_stim(1, 128, 128);
    run_sweep();
    check("int_spike6", seen, 4'b0010);
    check("int_done6", done_at_end, 1);
    check("int_spikes6", spikes, 4'b0010);
    read_state(1, v);
    check("int_state6", v, 0);
    // Pending current is consumed; the second sweep only leaks
    apply_reset();
    write_stim(1, 128, 128);
    run_sweep();
    run_sweep();
    read_state(1, v);
    check("leak_only", v, 48);
    check("leak_spikes", spikes, 0);

    // Handshake stalled while busy; tick during sweep ignored
    apply_reset();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
    in_valid = 1'b1; in_idx = 2'd3; in_current = 8'd255; in_weight = 8'd255;
    for (int k = 3; k <= 9; k++) begin
      check($sformatf("hs_ready_t%0d", k), in_ready, 0);
      if (k == 5) tick = 1'b1;
      step();
      tick = 1'b0;
    end
    check("hs_ready_t10", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("hs_busy_t11", busy, 0);
    step();
    step();
    check("hs_busy_t13", busy, 0);
    run_sweep();
    check("hs_transfer_fire", seen, 4'b1000);

    // Tick and write in the same IDLE cycle
    apply_reset();
    in_valid = 1'b1; in_idx = 2'd2; in_current = 8'd255; in_weight = 8'd255;
    tick = 1'b1;
    step();
    in_valid = 1'b0;
    tick = 1'b0;
    repeat (5) step();
    check("sim_sv_t6", spike_valid, 0);
    step();
    check("sim_sv_t7", spike_valid, 1);
    check("sim_idx_t7", spike_idx, 2);
    repeat (2) step();
    check("sim_spikes_t9", spikes, 4'b0100);
    step();

    // Reset in the middle of a sweep
    apply_reset();
    write_stim(0, 255, 255);
    write_stim(1, 128, 128);
    run_sweep();
    check("mid_pre_spikes", spikes, 4'b0001);
    read_state(1, v);
    check("mid_pre_state1", v, 64);
    write_stim(2, 128, 128);
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_busy", busy, 0);
    check("mid_ready", in_ready, 1);
    check("mid_spikes", spikes, 0);
    check("mid_done", done, 0);
    for (int i = 0; i < N; i++) begin
      read_state(i, v);
      check($sformatf("mid_state%0d", i), v, 0);
    end
    write_stim(0, 255, 255);
    run_sweep();
    check("mid_busy_cnt", busy_cnt, 2 * N + 1);
    check("mid_done_cnt", done_cnt, 1);
    check("mid_done_last", done_at_end, 1);
    check("mid_busy_after", busy, 0);
    check("mid_new_spikes", spikes, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
